// File: rtl/adc_spi_receptor.sv
// Serial ADC receiver: synchronises SClk/CS/SData onto MasterClk and deserialises each CS-low frame.
// Optional ADC_PROMEDIO_EN: report the truncated mean of every four consecutive samples.
module adc_spi_receptor #(
  parameter int DATA_W      = 12,
  parameter int LEAD_BITS   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              MasterClk,
  input  logic              reset,
  input  logic              SClk,
  input  logic              CS,
  input  logic              SData,
  output logic [DATA_W-1:0] dato,
  output logic              dato_valido,
  output logic              error_trama,
  output logic [4:0]        conteo_bits
);

  localparam int FRAME_W = LEAD_BITS + DATA_W;

  typedef enum logic [1:0] {REPOSO, CAPTURA, ENTREGA, DESCARTE} estado_t;

  estado_t                estado;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, sdata_sync;
  logic                   sclk_prev, cs_prev;
  logic [SYNC_STAGES:0]   arranque;
  logic                   armado;
  logic [DATA_W-2:0]      shreg;

  logic sclk_s, cs_s, sdata_s;
  logic sclk_sube, cs_baja, cs_sube;
  logic [DATA_W-1:0] muestra;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sdata_s   = sdata_sync[SYNC_STAGES-1];
  assign sclk_sube = sclk_s & ~sclk_prev;
  // A fall is only trusted once CS has really been seen high since reset.
  assign cs_baja   = ~cs_s & cs_prev & armado;
  assign cs_sube   = cs_s & ~cs_prev;
  assign muestra   = {shreg, sdata_s};

  always_ff @(posedge MasterClk or negedge reset) begin
    if (!reset) begin
      sclk_sync  <= '0;
      cs_sync    <= '1;
      sdata_sync <= '0;
      sclk_prev  <= 1'b0;
      cs_prev    <= 1'b1;
      arranque   <= '0;
      armado     <= 1'b0;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], SClk};
      cs_sync    <= {cs_sync[SYNC_STAGES-2:0], CS};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], SData};
      sclk_prev  <= sclk_s;
      cs_prev    <= cs_s;
      arranque   <= {arranque[SYNC_STAGES-1:0], 1'b1};
      if (arranque[SYNC_STAGES] && cs_s)
        armado <= 1'b1;
    end
  end

`ifdef ADC_PROMEDIO_EN
  logic [1:0]        bloque;
  logic [DATA_W+1:0] acum;
  logic [DATA_W+1:0] suma;
  assign suma = acum + {2'b00, muestra};
`endif

  always_ff @(posedge MasterClk or negedge reset) begin
    if (!reset) begin
      estado      <= REPOSO;
      shreg       <= '0;
      conteo_bits <= '0;
      dato        <= '0;
      dato_valido <= 1'b0;
      error_trama <= 1'b0;
`ifdef ADC_PROMEDIO_EN
      bloque      <= '0;
      acum        <= '0;
`endif
    end else begin
      dato_valido <= 1'b0;
      case (estado)
        REPOSO: begin
          if (cs_baja) begin
            estado      <= CAPTURA;
            conteo_bits <= '0;
            shreg       <= '0;
          end
        end
        CAPTURA: begin
          if (sclk_sube) begin
            shreg       <= muestra[DATA_W-2:0];
            conteo_bits <= conteo_bits + 5'd1;
            if (conteo_bits < 5'(LEAD_BITS) && sdata_s)
              error_trama <= 1'b1;
            // Output is registered on the last edge so the pulse lands in the ENTREGA cycle.
            if (conteo_bits == 5'(FRAME_W - 1)) begin
              estado <= ENTREGA;
`ifdef ADC_PROMEDIO_EN
              if (bloque == 2'd3) begin
                dato        <= DATA_W'(suma >> 2);
                dato_valido <= 1'b1;
                acum        <= '0;
                bloque      <= '0;
              end else begin
                acum   <= suma;
                bloque <= bloque + 2'd1;
              end
`else
              dato        <= muestra;
              dato_valido <= 1'b1;
`endif
            end else if (cs_sube) begin
              error_trama <= 1'b1;
              estado      <= REPOSO;
            end
          end else if (cs_sube) begin
            error_trama <= 1'b1;
            estado      <= REPOSO;
          end
        end
        ENTREGA: begin
          estado <= cs_s ? REPOSO : DESCARTE;
        end
        DESCARTE: begin
          if (cs_sube)
            estado <= REPOSO;
        end
        default: estado <= REPOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_spi_receptor.sv
// Randomised bench for adc_spi_receptor with a frame-level reference model and per-cycle output checks.
// Build with ADC_PROMEDIO_EN defined to exercise the four-sample averaging variant.
module tb_adc_spi_receptor;
  localparam int DW = 12;
  localparam int LB = 4;
  localparam int SS = 2;

  logic MasterClk = 1'b0;
  logic reset = 1'b0;
  logic SClk = 1'b0;
  logic CS = 1'b1;
  logic SData = 1'b0;
  logic [DW-1:0] dato;
  logic dato_valido, error_trama;
  logic [4:0] conteo_bits;

  adc_spi_receptor #(.DATA_W(DW), .LEAD_BITS(LB), .SYNC_STAGES(SS)) dut (
    .MasterClk(MasterClk), .reset(reset), .SClk(SClk), .CS(CS), .SData(SData),
    .dato(dato), .dato_valido(dato_valido), .error_trama(error_trama),
    .conteo_bits(conteo_bits)
  );

  always #5 MasterClk = ~MasterClk;

  int cyc = 0;
  always @(posedge MasterClk) cyc <= cyc + 1;

  int n_pass = 0, n_tot = 0;
  typedef struct {int cyc; logic [DW-1:0] val; logic err;} exp_t;
  exp_t expq[$];

  // reference model state
  logic m_err = 1'b0;
  bit m_cap = 1'b0;
  int m_n = 0;
  logic [15:0] m_sh = '0;
  int m_blk = 0, m_acc = 0;
  int H = 3;
  int pulses = 0;
  logic [DW-1:0] m_dato_c = '0;
  logic err_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    else n_pass++;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge MasterClk);
    #1;
  endtask

  task automatic model_reset();
    m_err = 1'b0; m_cap = 1'b0; m_n = 0; m_sh = '0; m_blk = 0; m_acc = 0;
  endtask

  // The pulse is due SS+1 cycles after the drive of the 16th rising SClk.
  task automatic deliver(input logic [DW-1:0] v);
    exp_t e;
    e.cyc = cyc + SS + 1;
    e.err = m_err;
`ifdef ADC_PROMEDIO_EN
    m_acc += int'(v);
    m_blk++;
    if (m_blk == 4) begin
      e.val = DW'(m_acc >> 2);
      expq.push_back(e);
      m_acc = 0;
      m_blk = 0;
    end
`else
    e.val = v;
    expq.push_back(e);
`endif
  endtask

  task automatic frame_start(input bit coin);
    if (coin) begin
      CS = 1'b0; SClk = 1'b1; SData = 1'($urandom);
      wait_cyc(H);
      SClk = 1'b0;
      wait_cyc(H);
    end else begin
      CS = 1'b0;
      wait_cyc(H);
    end
    m_cap = 1'b1; m_n = 0; m_sh = '0;
  endtask

  task automatic sclk_edge(input logic b, input bit rcs);
    SData = b;
    wait_cyc(H);
    SClk = 1'b1;
    if (rcs) CS = 1'b1;
    if (m_cap) begin
      m_sh = {m_sh[14:0], b};
      if (m_n < LB && b) m_err = 1'b1;
      m_n++;
      if (m_n == 16) begin
        deliver(m_sh[DW-1:0]);
        m_cap = 1'b0;
      end else if (rcs) begin
        m_err = 1'b1;
        m_cap = 1'b0;
      end
    end
    wait_cyc(H);
    SClk = 1'b0;
  endtask

  task automatic frame_end();
    wait_cyc(H);
    if (!CS) begin
      CS = 1'b1;
      if (m_cap) begin
        m_err = 1'b1;
        m_cap = 1'b0;
      end
    end
    wait_cyc(4);
  endtask

  task automatic send(input logic [15:0] w, input int nedges, input bit cs_in, input bit ce);
    logic [15:0] ww;
    ww = w;
    frame_start(cs_in);
    for (int i = 0; i < nedges; i++)
      sclk_edge((i < 16) ? ww[15-i] : 1'($urandom), ce && (i == nedges - 1));
    frame_end();
  endtask

  always @(negedge MasterClk) begin
    if (!reset) begin
      m_dato_c = '0;
      err_prev = 1'b0;
      expq.delete();
    end else begin
      if (expq.size() > 0 && expq[0].cyc == cyc) begin
        chk("pulse_present", dato_valido, 1);
        chk("pulse_dato", dato, expq[0].val);
        chk("pulse_error_trama", error_trama, expq[0].err);
        m_dato_c = expq[0].val;
        void'(expq.pop_front());
      end else if (dato_valido) begin
        chk("unexpected_pulse", dato_valido, 0);
      end else begin
        chk("dato_hold", dato, m_dato_c);
      end
      if (err_prev) chk("error_sticky", error_trama, 1);
      err_prev = error_trama;
      if (dato_valido) pulses++;
    end
  end

  initial begin
    int p0;
    logic [15:0] w;
    int ne;
    logic [15:0] w5a5;
    w5a5 = 16'h05A5;

    wait_cyc(3);
    chk("reset_dato", dato, 0);
    chk("reset_valido", dato_valido, 0);
    chk("reset_error", error_trama, 0);
    chk("reset_conteo", conteo_bits, 0);
    reset = 1'b1;
    wait_cyc(6);

    // nominal frame
    p0 = pulses;
    send(16'h0ABC, 16, 0, 0);
    chk("nominal_error", error_trama, 0);
`ifndef ADC_PROMEDIO_EN
    chk("nominal_dato", dato, 12'hABC);
    chk("nominal_pulses", pulses - p0, 1);
`endif

    // short frame: CS rises after 9 bits
    p0 = pulses;
    send(16'h0123, 9, 0, 0);
    chk("short_error", error_trama, 1);
    chk("short_pulses", pulses - p0, 0);
`ifndef ADC_PROMEDIO_EN
    chk("short_dato", dato, 12'hABC);
`endif

    // divider-length frame, 33 SClk periods
    p0 = pulses;
    frame_start(0);
    for (int i = 0; i < 33; i++) sclk_edge((i < 15) ? 1'b0 : 1'b1, 0);
    wait_cyc(4);
    chk("divider_conteo", conteo_bits, 16);
    frame_end();
    chk("divider_error_still", error_trama, 1);
`ifndef ADC_PROMEDIO_EN
    chk("divider_dato", dato, 12'h001);
    chk("divider_pulses", pulses - p0, 1);
`endif

    // leading-bit error
    p0 = pulses;
    send(16'h4FFF, 16, 0, 0);
    chk("lead_error", error_trama, 1);
`ifndef ADC_PROMEDIO_EN
    chk("lead_dato", dato, 12'hFFF);
    chk("lead_pulses", pulses - p0, 1);
`endif

    // reset mid-frame, released while CS is still low
    frame_start(0);
    for (int i = 0; i < 7; i++) sclk_edge(w5a5[15-i], 0);
    wait_cyc(4);
    chk("mid_conteo", conteo_bits, 7);
    reset = 1'b0;
    model_reset();
    wait_cyc(2);
    chk("mid_reset_dato", dato, 0);
    chk("mid_reset_valido", dato_valido, 0);
    chk("mid_reset_error", error_trama, 0);
    chk("mid_reset_conteo", conteo_bits, 0);
    reset = 1'b1;
    wait_cyc(8);
    p0 = pulses;
    for (int i = 0; i < 16; i++) sclk_edge(w5a5[15-i], 0);
    wait_cyc(4);
    chk("held_low_pulses", pulses - p0, 0);
    chk("held_low_conteo", conteo_bits, 0);
    frame_end();
    p0 = pulses;
    send(16'h05A5, 16, 0, 0);
    chk("after_reset_error", error_trama, 0);
`ifndef ADC_PROMEDIO_EN
    chk("after_reset_dato", dato, 12'h5A5);
    chk("after_reset_pulses", pulses - p0, 1);
`endif

    // randomised frames, including coincident CS/SClk edges and short frames
    for (int f = 0; f < 60; f++) begin
      H = $urandom_range(2, 5);
      w = 16'($urandom);
      if ($urandom_range(0, 9) != 0) w[15:12] = 4'h0;
      if ($urandom_range(0, 9) == 0) ne = $urandom_range(1, 15);
      else ne = 16 + $urandom_range(0, 17);
      send(w, ne, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    // four-sample block after a clean reset
    H = 3;
    reset = 1'b0;
    model_reset();
    wait_cyc(2);
    reset = 1'b1;
    wait_cyc(6);
    p0 = pulses;
    send(16'h0100, 16, 0, 0);
    send(16'h0200, 16, 0, 0);
    send(16'h0300, 16, 0, 0);
`ifdef ADC_PROMEDIO_EN
    chk("avg_no_early_pulse", pulses - p0, 0);
`else
    chk("block_three_pulses", pulses - p0, 3);
`endif
    send(16'h0401, 16, 0, 0);
`ifdef ADC_PROMEDIO_EN
    chk("avg_dato", dato, 12'h280);
    chk("avg_pulses", pulses - p0, 1);
`else
    chk("block_last_dato", dato, 12'h401);
    chk("block_pulses", pulses - p0, 4);
`endif

    wait_cyc(10);
    chk("pending_pulses", expq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/adc_spi_receptor.md
Name: adc_spi_receptor

Overview:
- Serial ADC capture stage directly downstream of the SClk/CS frequency-divider block.
- Runs entirely on MasterClk. Synchronises the divider's SClk and CS and the ADC's serial data line, then deserialises each CS-low frame (leading zeros + DATA_W data bits, MSB first).
- Presents each sample as a parallel word with a one-cycle valid strobe to the downstream processing/display logic.

Parameters:
- DATA_W, 12, number of data bits per frame.
- LEAD_BITS, 4, leading bits before data; these must be zero.
- SYNC_STAGES, 2, flip-flop synchroniser depth on SClk, CS and SData (minimum 2).

Ports:
- MasterClk  in  1  system clock; the only clock in the block.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- SClk  in  1  serial clock from the divider; asynchronous to the block, sampled as data.
- CS  in  1  ADC chip select from the divider; a frame is active while CS = 0.
- SData  in  1  serial data from the ADC.
- dato  out  DATA_W  last complete sample, held until the next one.
- dato_valido  out  1  one-MasterClk-cycle pulse when dato updates.
- error_trama  out  1  sticky flag: short frame or non-zero leading bit. Cleared only by reset.
- conteo_bits  out  5  bits received in the current frame, for debug.

Behaviour:
- Reset (reset = 0, asynchronous):
  - dato = 0, dato_valido = 0, error_trama = 0, conteo_bits = 0.
  - State = REPOSO; shift register = 0.
  - Synchroniser flops reset to SClk = 0, CS = 1, SData = 0.
- Synchronisers and edge detection:
  - SClk, CS and SData each pass through SYNC_STAGES flops, plus one extra flop on SClk and CS for edge detection.
  - sclk_sube = sync & ~prev. cs_baja = ~sync & prev. cs_sube = sync & ~prev.
  - SData is sampled from its synchronised output in the same cycle sclk_sube is detected, so all three inputs see equal delay.
- FSM states:
  - REPOSO: wait for cs_baja → CAPTURA; clear the bit counter and shift register.
  - CAPTURA: on each sclk_sube, shift SData into the LSB and increment the counter.
    - If a leading bit (counter < LEAD_BITS) is 1, set error_trama but keep capturing.
    - When the counter reaches LEAD_BITS+DATA_W (16) → ENTREGA.
  - ENTREGA: one cycle. Load dato with the low DATA_W bits, pulse dato_valido = 1 → DESCARTE.
  - DESCARTE: ignore any further SClk edges (the divider keeps CS low for 33 SClk periods). Wait for cs_sube → REPOSO.
- Latency: dato_valido is high in the cycle after the detection cycle of the 16th sclk_sube, for exactly one cycle.
- Boundary conditions:
  - cs_sube in CAPTURA before 16 bits: set error_trama, leave dato and dato_valido untouched, → REPOSO.
  - cs_baja and sclk_sube in the same cycle: the edge is not captured; the frame starts from the next sclk_sube.
  - cs_sube and the 16th sclk_sube in the same cycle: the frame completes (ENTREGA), then → REPOSO.
  - conteo_bits saturates at 16 and never wraps.
  - Reset asserted mid-frame: immediate return to reset values. The next frame starts only on a fresh cs_baja, so a CS that is already low after reset release is not captured until CS rises and falls again.
  - SClk edges while CS = 1 are ignored in every state.

Optional Feature:
- Macro ADC_PROMEDIO_EN.
- Defined:
  - A 2-bit block counter and a (DATA_W+2)-bit accumulator sum four consecutive valid samples.
  - On the 4th sample, dato = accumulator >> 2 (truncating). dato_valido pulses only then, and the accumulator and counter clear.
  - Short frames do not advance the block counter.
  - Reset clears both.
- Not defined: every valid frame updates dato directly; no accumulator logic is synthesised.

Test Plan:
- Nominal frame: CS low, 16 SClk periods shifting 0000_1010_1011_1100 → dato = 12'hABC, one dato_valido pulse, error_trama = 0.
- Divider-length frame: CS low for 33 SClk periods carrying 0000_0000_0000_0001 then 17 ones → dato = 12'h001, exactly one pulse, extra bits ignored.
- Short frame: CS rises after 9 bits → no pulse, dato keeps its prior value 12'hABC, error_trama = 1 and still 1 after a following good frame.
- Leading-bit error: frame 0100_1111_1111_1111 → dato = 12'hFFF, pulse issued, error_trama = 1.
- Reset mid-frame: reset = 0 after 7 bits, release with CS still low → all outputs 0, no capture until CS toggles high then low; the next frame 12'h5A5 is captured correctly.
- ADC_PROMEDIO_EN: samples 12'h100, 12'h200, 12'h300, 12'h401 → a single pulse with dato = 12'h280; no pulse after the first three samples.
